// File: rtl/wshb_ram_pkg.sv
// ---------------------------------------------------------------------------
// wshb_ram_pkg
// Shared types for the Wishbone RAM slave: bus cycle-type codes, the slave
// FSM state encoding, the supported burst type and a small state decoder.
// ---------------------------------------------------------------------------
package wshb_ram_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    ACK   = 3'd2,
    BURST = 3'd3,
    ERR   = 3'd4
  } state_t;

  // Only linear incrementing bursts are served.
  localparam logic [1:0] BTE_LINEAR = 2'b00;

  // States in which the slave drives ack (and the RAM beat is live).
  function automatic logic is_resp(input state_t s);
    return (s == ACK) || (s == BURST);
  endfunction

endpackage

// File: rtl/wshb_ram_sp.sv
// ---------------------------------------------------------------------------
// wshb_ram_sp
// Single-port DEPTH x 16 RAM with two byte enables and a registered read.
// Ports:
//   clk    in   clock
//   addr   in   word address (AW bits), shared by read and write
//   wdata  in   write data
//   be     in   byte write enables, be[1] -> wdata[15:8]
//   rdata  out  registered read data (old contents on a same-address write)
// ---------------------------------------------------------------------------
module wshb_ram_sp #(
  parameter int    DEPTH     = 4096,
  parameter int    AW        = 12,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  input  logic [1:0]    be,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  // Byte-masked write and synchronous read on one shared port.
  always_ff @(posedge clk) begin
    if (be[0]) begin
      mem[addr][7:0] <= wdata[7:0];
    end
    if (be[1]) begin
      mem[addr][15:8] <= wdata[15:8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/wshb_ram_slave.sv
// ---------------------------------------------------------------------------
// wshb_ram_slave
// 16-bit Wishbone B4 slave backed by on-chip RAM. Classic cycles, linear
// incrementing bursts and WAIT_STATES extra cycles before the first ack.
// Ports:
//   CLK, NRST        clock, asynchronous active-low reset
//   adr[31:0]        byte address, word index adr[AW:1]
//   dat_ms[15:0]     write data          sel[1:0]  byte selects
//   we, cyc, stb     write / cycle / strobe
//   cti[2:0]         cycle type          bte[1:0]  burst type
//   dat_sm[15:0]     read data (0 whenever ack is low)
//   ack, err, rty    terminations (rty is never used)
// ---------------------------------------------------------------------------
module wshb_ram_slave
  import wshb_ram_pkg::*;
#(
  parameter int    DEPTH       = 4096,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic [31:0] adr,
  input  logic [15:0] dat_ms,
  input  logic [1:0]  sel,
  input  logic        we,
  input  logic        cyc,
  input  logic        stb,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [15:0] dat_sm,
  output logic        ack,
  output logic        err,
  output logic        rty
);

  localparam int         AW    = $clog2(DEPTH);
  localparam logic [3:0] WS_M1 = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t        state_r, state_n;
  logic [3:0]    cnt_r, cnt_n;
  logic [AW-1:0] adr_q_r, adr_n;
  logic          ack_r, err_r;

  logic          req_s, oor_s, wr_en_s;
  logic [AW-1:0] adr_word_s, ram_addr_s;
  logic [1:0]    ram_be_s;
  logic [15:0]   ram_q_s;
  logic          unused_adr_s;

  assign req_s        = cyc & stb;
  assign adr_word_s   = adr[AW:1];
  assign unused_adr_s = adr[0];
  assign oor_s        = (|adr[31:AW+1]) ||
                        ((cti == CTI_INCR) && (bte != BTE_LINEAR));

  // A beat writes only while the master still holds the cycle at the closing edge.
  assign wr_en_s  = is_resp(state_r) & we & req_s;
  assign ram_be_s = sel & {2{wr_en_s}};
  // Reads look ahead to the address of the next beat so the registered RAM
  // output lines up with the ack cycle; writes use the current beat address.
  assign ram_addr_s = wr_en_s ? adr_q_r : adr_n;

  // Next-state, wait counter and beat address.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    adr_n   = adr_q_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          adr_n = adr_word_s;
          if (oor_s) begin
            state_n = ERR;
          end else if (WAIT_STATES == 0) begin
            state_n = ACK;
          end else begin
            state_n = WAIT;
            cnt_n   = WS_M1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (!req_s) begin
          state_n = IDLE;
        end else if (cnt_r == 4'd0) begin
          state_n = ACK;
        end else begin
          cnt_n = cnt_r - 4'd1;
        end
      end
      ACK, BURST: begin
        if (req_s && (cti == CTI_INCR)) begin
          // Running off the top of the RAM terminates the burst with err.
          if (&adr_q_r) begin
            state_n = ERR;
          end else begin
            state_n = BURST;
            adr_n   = adr_q_r + AW'(1'b1);
          end
        end else begin
          state_n = IDLE;
        end
      end
      ERR: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, counter, address and registered terminations.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      adr_q_r <= {AW{1'b0}};
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      adr_q_r <= adr_n;
      ack_r   <= is_resp(state_n);
      err_r   <= (state_n == ERR);
    end
  end

  wshb_ram_sp #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (CLK),
    .addr (ram_addr_s),
    .wdata(dat_ms),
    .be   (ram_be_s),
    .rdata(ram_q_s)
  );

  assign ack    = ack_r;
  assign err    = err_r;
  assign rty    = 1'b0;
  assign dat_sm = ack_r ? ram_q_s : 16'h0000;

endmodule
